// File: rtl/wir_pkg.sv
// Shared types and constants for the WIR load sequencer and its requesters.
package wir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE,
        ST_DONE
    } wir_state_t;

    localparam int WIR_LEN_DEF = 3;

    // Instruction opcodes for the default 3-cell WIR.
    localparam logic [WIR_LEN_DEF-1:0] OP_BYPASS = 3'b111;
    localparam logic [WIR_LEN_DEF-1:0] OP_EXTEST = 3'b000;
    localparam logic [WIR_LEN_DEF-1:0] OP_INTEST = 3'b001;

endpackage

// File: rtl/wir_load_sequencer_if.sv
// Host load handshake plus the serial WIR strobes and readback.
interface wir_load_sequencer_if
    import wir_pkg::*;
#(
    parameter int WIR_LEN = WIR_LEN_DEF
);
    logic               load_req;
    logic [WIR_LEN-1:0] load_instr;
    logic               load_ack;
    logic               busy;
    logic               wir_si;
    logic               wir_capture;
    logic               wir_shift;
    logic               wir_update;
    logic               wir_so;
    logic [WIR_LEN-1:0] readback;
    logic               readback_valid;

    // Requester side, which also owns the WIR chain.
    modport master (
        output load_req, load_instr, wir_so,
        input  load_ack, busy, wir_si, wir_capture, wir_shift, wir_update,
               readback, readback_valid
    );

    // Sequencer side.
    modport slave (
        input  load_req, load_instr, wir_so,
        output load_ack, busy, wir_si, wir_capture, wir_shift, wir_update,
               readback, readback_valid
    );
endinterface

// File: rtl/wir_load_sequencer.sv
// Runs one capture -> shift -> update transaction on the WIR per accepted
// request and returns the displaced instruction as a parallel readback.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for load_req while armed; re-arms on load_req low
// CAPTURE | one cycle of wir_capture, counter cleared
// SHIFT   | WIR_LEN cycles of wir_shift, new bits out, old bits in
// UPDATE  | one cycle of wir_update, readback loaded from shadow
// DONE    | one cycle of load_ack
module wir_load_sequencer
    import wir_pkg::*;
#(
    parameter int WIR_LEN = WIR_LEN_DEF
) (
    input  logic                 WRCK,
    input  logic                 WRSTN,
    wir_load_sequencer_if.slave  bus
);
    localparam int               CNT_W    = $clog2(WIR_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIR_LEN - 1);

    wir_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIR_LEN-1:0] sh, sh_nxt;
    logic [WIR_LEN-1:0] rb, rb_nxt;
    logic               armed, armed_nxt;
    logic               rbv, rbv_nxt;
    logic               capture_q, shift_q, update_q, ack_q, busy_q, si_q;

    // Next-state, counter, shadow shifter and readback updates.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sh_nxt    = sh;
        armed_nxt = armed;
        rb_nxt    = rb;
        rbv_nxt   = rbv;
        case (state)
            ST_IDLE: begin
                if (!bus.load_req) begin
                    armed_nxt = 1'b1;
                end else if (armed) begin
                    sh_nxt    = bus.load_instr;
                    armed_nxt = 1'b0;
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                cnt_nxt   = '0;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Shift/OR form stays legal when the chain is a single cell.
                sh_nxt  = (sh >> 1) | (WIR_LEN'(bus.wir_so) << (WIR_LEN - 1));
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_LAST) state_nxt = ST_UPDATE;
            end
            ST_UPDATE: begin
                rb_nxt    = sh;
                rbv_nxt   = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register plus outputs registered from the next-state decode.
    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sh        <= '0;
            rb        <= '0;
            armed     <= 1'b1;
            rbv       <= 1'b0;
            capture_q <= 1'b0;
            shift_q   <= 1'b0;
            update_q  <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            si_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sh        <= sh_nxt;
            rb        <= rb_nxt;
            armed     <= armed_nxt;
            rbv       <= rbv_nxt;
            capture_q <= (state_nxt == ST_CAPTURE);
            shift_q   <= (state_nxt == ST_SHIFT);
            update_q  <= (state_nxt == ST_UPDATE);
            ack_q     <= (state_nxt == ST_DONE);
            busy_q    <= (state_nxt != ST_IDLE);
            si_q      <= (state_nxt == ST_SHIFT) && sh_nxt[0];
        end
    end

    assign bus.wir_capture    = capture_q;
    assign bus.wir_shift      = shift_q;
    assign bus.wir_update     = update_q;
    assign bus.load_ack       = ack_q;
    assign bus.busy           = busy_q;
    assign bus.wir_si         = si_q;
    assign bus.readback       = rb;
    assign bus.readback_valid = rbv;

endmodule

// File: tb/tb_wir_load_sequencer.sv
// Directed bench for the WIR load sequencer with 3-cell and 1-cell chains.
module tb_wir_load_sequencer;

    logic WRCK = 1'b0;
    logic WRSTN;
    int   n_tests = 0;
    int   n_fail  = 0;

    wir_load_sequencer_if #(.WIR_LEN(3)) i3();
    wir_load_sequencer_if #(.WIR_LEN(1)) i1();

    wir_load_sequencer #(.WIR_LEN(3)) dut3 (.WRCK(WRCK), .WRSTN(WRSTN), .bus(i3.slave));
    wir_load_sequencer #(.WIR_LEN(1)) dut1 (.WRCK(WRCK), .WRSTN(WRSTN), .bus(i1.slave));

    always #5 WRCK = ~WRCK;

    // WIR chain models: capture reloads from the update stage, shift enters at the top cell.
    logic [2:0] c3, u3, pv3;
    logic       c1, u1, pv1;
    logic       pre3 = 1'b0, pre1 = 1'b0;

    always @(posedge WRCK) begin
        if (pre3) begin
            c3 <= pv3;
            u3 <= pv3;
        end else begin
            if (i3.wir_capture)    c3 <= u3;
            else if (i3.wir_shift) c3 <= {i3.wir_si, c3[2:1]};
            if (i3.wir_update)     u3 <= c3;
        end
        if (pre1) begin
            c1 <= pv1;
            u1 <= pv1;
        end else begin
            if (i1.wir_capture)    c1 <= u1;
            else if (i1.wir_shift) c1 <= i1.wir_si;
            if (i1.wir_update)     u1 <= c1;
        end
    end
    assign i3.wir_so = c3[0];
    assign i1.wir_so = c1;

    // Runs one load on the selected DUT; k counts sample points after the acceptance edge.
    task automatic do_load(input bit sel, input logic [2:0] instr, input bit hold,
                           output int lat, output int ncap, output int nshift,
                           output int nupd, output logic [2:0] si_seq, output logic ack_next);
        logic cap, shf, upd, si, ack;
        lat = -1; ncap = 0; nshift = 0; nupd = 0; si_seq = '0; ack_next = 1'b1;
        @(negedge WRCK);
        if (sel) begin i1.load_instr = instr[0]; i1.load_req = 1'b1; end
        else     begin i3.load_instr = instr;    i3.load_req = 1'b1; end
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge WRCK);
            if (k == 0) begin
                if (sel) i1.load_instr = ~instr[0];
                else     i3.load_instr = ~instr;
            end
            cap = sel ? i1.wir_capture : i3.wir_capture;
            shf = sel ? i1.wir_shift   : i3.wir_shift;
            upd = sel ? i1.wir_update  : i3.wir_update;
            si  = sel ? i1.wir_si      : i3.wir_si;
            ack = sel ? i1.load_ack    : i3.load_ack;
            if (cap) ncap++;
            if (shf) begin
                if (nshift < 3) si_seq[nshift] = si;
                nshift++;
            end
            if (upd) nupd++;
            if (ack) lat = k;
        end
        if (!hold) begin
            if (sel) i1.load_req = 1'b0; else i3.load_req = 1'b0;
        end
        @(negedge WRCK);
        ack_next = sel ? i1.load_ack : i3.load_ack;
        @(negedge WRCK);
    endtask

    task automatic test_reset();
        logic [7:0] outs3;
        logic [3:0] outs1;
        int         lat;
        WRSTN = 1'b0;
        i3.load_req = 1'b1; i3.load_instr = 3'b010;
        i1.load_req = 1'b0; i1.load_instr = 1'b0;
        pv3 = 3'b000; pv1 = 1'b0; pre3 = 1'b1; pre1 = 1'b1;
        repeat (2) @(negedge WRCK);
        pre3 = 1'b0; pre1 = 1'b0;
        outs3 = {i3.wir_capture, i3.wir_shift, i3.wir_update, i3.load_ack,
                 i3.busy, i3.wir_si, i3.readback_valid, |i3.readback};
        n_tests++;
        if (outs3 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outs3: got %b expected 00000000", outs3);
        end
        outs1 = {i1.wir_capture, i1.wir_shift, i1.load_ack, i1.readback};
        n_tests++;
        if (outs1 !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outs1: got %b expected 0000", outs1);
        end
        WRSTN = 1'b1;
        @(negedge WRCK);
        n_tests++;
        if (i3.wir_capture !== 1'b1 || i3.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_capture: got cap=%b busy=%b expected 1 1",
                     i3.wir_capture, i3.busy);
        end
        lat = -1;
        for (int k = 1; k < 20 && lat < 0; k++) begin
            @(negedge WRCK);
            if (i3.load_ack) lat = k;
        end
        i3.load_req = 1'b0;
        repeat (2) @(negedge WRCK);
        n_tests++;
        if (lat !== 5 || u3 !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_first_load: got lat=%0d chain=%b expected 5 010", lat, u3);
        end
    endtask

    task automatic test_normal_load();
        int lat, nc, ns, nu;
        logic [2:0] si;
        logic an;
        do_load(1'b0, 3'b101, 1'b0, lat, nc, ns, nu, si, an);
        n_tests++;
        if (nc !== 1 || ns !== 3 || nu !== 1) begin
            n_fail++;
            $display("FAIL normal_strobes: got cap=%0d shift=%0d upd=%0d expected 1 3 1", nc, ns, nu);
        end
        n_tests++;
        if (si !== 3'b101) begin
            n_fail++;
            $display("FAIL normal_si_seq: got %b expected 101", si);
        end
        n_tests++;
        if (u3 !== 3'b101) begin
            n_fail++;
            $display("FAIL normal_chain: got %b expected 101", u3);
        end
        n_tests++;
        if (i3.readback !== 3'b010 || i3.readback_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_readback: got %b valid=%b expected 010 1", i3.readback, i3.readback_valid);
        end
        n_tests++;
        if (lat !== 5 || an !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_ack: got lat=%0d ack_next=%b expected 5 0", lat, an);
        end
    endtask

    task automatic test_held_request();
        int lat, nc, ns, nu, extra_cap, extra_ack;
        logic [2:0] si;
        logic an;
        do_load(1'b0, 3'b100, 1'b1, lat, nc, ns, nu, si, an);
        n_tests++;
        if (lat !== 5 || u3 !== 3'b100) begin
            n_fail++;
            $display("FAIL held_first: got lat=%0d chain=%b expected 5 100", lat, u3);
        end
        extra_cap = 0; extra_ack = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge WRCK);
            if (i3.wir_capture) extra_cap++;
            if (i3.load_ack || i3.busy) extra_ack++;
        end
        n_tests++;
        if (extra_cap !== 0 || extra_ack !== 0) begin
            n_fail++;
            $display("FAIL held_no_restart: got cap=%0d busy_or_ack=%0d expected 0 0", extra_cap, extra_ack);
        end
        i3.load_req = 1'b0;
        do_load(1'b0, 3'b011, 1'b0, lat, nc, ns, nu, si, an);
        n_tests++;
        if (lat !== 5 || nc !== 1 || i3.readback !== 3'b100 || u3 !== 3'b011) begin
            n_fail++;
            $display("FAIL held_rearm: got lat=%0d cap=%0d rb=%b chain=%b expected 5 1 100 011",
                     lat, nc, i3.readback, u3);
        end
    endtask

    task automatic test_readback_chain();
        int lat, nc, ns, nu;
        logic [2:0] si;
        logic an;
        do_load(1'b0, 3'b110, 1'b0, lat, nc, ns, nu, si, an);
        n_tests++;
        if (i3.readback !== 3'b011) begin
            n_fail++;
            $display("FAIL chain_rb1: got %b expected 011", i3.readback);
        end
        do_load(1'b0, 3'b001, 1'b0, lat, nc, ns, nu, si, an);
        n_tests++;
        if (i3.readback !== 3'b110 || u3 !== 3'b001) begin
            n_fail++;
            $display("FAIL chain_rb2: got rb=%b chain=%b expected 110 001", i3.readback, u3);
        end
    endtask

    task automatic test_reset_mid_shift();
        int acks;
        @(negedge WRCK);
        i3.load_instr = 3'b011; i3.load_req = 1'b1;
        repeat (3) @(posedge WRCK);
        #2;
        n_tests++;
        if (i3.wir_shift !== 1'b1) begin
            n_fail++;
            $display("FAIL midshift_in_shift: got %b expected 1", i3.wir_shift);
        end
        WRSTN = 1'b0;
        #1;
        n_tests++;
        if (i3.wir_shift !== 1'b0 || i3.busy !== 1'b0 || i3.readback !== 3'b000 ||
            i3.readback_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midshift_reset: got shift=%b busy=%b rb=%b valid=%b expected 0 0 000 0",
                     i3.wir_shift, i3.busy, i3.readback, i3.readback_valid);
        end
        i3.load_req = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge WRCK);
            if (k == 1) WRSTN = 1'b1;
            if (i3.load_ack) acks++;
        end
        n_tests++;
        if (acks !== 0) begin
            n_fail++;
            $display("FAIL midshift_no_ack: got %0d acks expected 0", acks);
        end
    endtask

    task automatic test_width_one();
        int lat, nc, ns, nu;
        logic [2:0] si;
        logic an;
        @(negedge WRCK);
        pv1 = 1'b0; pre1 = 1'b1;
        @(negedge WRCK);
        pre1 = 1'b0;
        do_load(1'b1, 3'b001, 1'b0, lat, nc, ns, nu, si, an);
        n_tests++;
        if (ns !== 1 || nc !== 1 || nu !== 1 || si[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_strobes: got cap=%0d shift=%0d upd=%0d si=%b expected 1 1 1 1",
                     nc, ns, nu, si[0]);
        end
        n_tests++;
        if (i1.readback !== 1'b0 || i1.readback_valid !== 1'b1 || u1 !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_result: got rb=%b valid=%b chain=%b expected 0 1 1",
                     i1.readback, i1.readback_valid, u1);
        end
        n_tests++;
        if (lat !== 3 || an !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_ack: got lat=%0d ack_next=%b expected 3 0", lat, an);
        end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_held_request();
        test_readback_chain();
        test_reset_mid_shift();
        test_width_one();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wir_load_sequencer.md
Name: wir_load_sequencer

Overview:
- Upstream driver for the wrapper instruction register (WIR) chain; generates the serial data input and the capture, shift and update strobes that the WIR cells consume.
- Takes a parallel instruction from a host-side requester and runs one complete capture -> shift -> update transaction on WRCK.
- Returns the previously held instruction, shifted out on wir_so, as a parallel readback word.

Parameters:
- WIR_LEN, 3, number of WIR cells in the chain (instruction width); legal range is 1 or more.
- CNT_W, $clog2(WIR_LEN+1), shift-counter width; derived, never overridden.

Ports:
- WRCK  input  1  wrapper clock; all state changes on its rising edge.
- WRSTN  input  1  asynchronous active-low reset.
- load_req  input  1  level request to load load_instr into the WIR.
- load_instr  input  WIR_LEN  instruction to install; bit 0 is the cell that drives wir_so.
- load_ack  output  1  one-cycle pulse marking transaction complete.
- busy  output  1  high from acceptance through the DONE cycle.
- wir_si  output  1  serial data into the WIR chain.
- wir_capture  output  1  WIR capture strobe.
- wir_shift  output  1  WIR shift strobe.
- wir_update  output  1  WIR update strobe.
- wir_so  input  1  serial data out of the WIR chain.
- readback  output  WIR_LEN  instruction that was resident before the last load.
- readback_valid  output  1  high once at least one transaction has completed since reset.

Behaviour:
- Clock and reset: one clock, WRCK; reset WRSTN is asynchronous, active-low.
- Reset values: every output is 0, state is IDLE, counter is 0, shadow register sh is 0, armed is 1.
- Output timing: all outputs come straight from flops, with no combinational path from inputs. At most one of capture, shift and update is high in any cycle.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, DONE.
- IDLE:
  - busy=0.
  - If load_req=1 and armed=1 at a rising edge, then sh <= load_instr, armed <= 0, and the FSM moves to CAPTURE.
  - armed <= 1 whenever load_req=0 is sampled in IDLE.
- CAPTURE: exactly 1 cycle; wir_capture=1, busy=1; counter <= 0.
- SHIFT:
  - Lasts exactly WIR_LEN cycles; wir_shift=1, wir_si=sh[0].
  - Each edge: sh <= {wir_so, sh[WIR_LEN-1:1]}, counter +1.
  - Leaves to UPDATE on the edge where counter == WIR_LEN-1.
  - After the last shift, chain cell i holds load_instr[i] and sh[i] holds the old cell-i value.
- UPDATE: exactly 1 cycle; wir_update=1; on exit, readback <= sh and readback_valid <= 1.
- DONE: exactly 1 cycle; load_ack=1, busy=1; returns to IDLE.
- Default levels: wir_si is 0 outside SHIFT.
- Latency: acceptance edge to load_ack high is WIR_LEN+2 cycles, and load_ack lasts 1 cycle. The total transaction is WIR_LEN+3 cycles including the IDLE acceptance.
- Handshake:
  - The requester holds load_req until load_ack, then drops it.
  - A req still high after DONE starts no new transaction until load_req=0 has been sampled (armed rule). Back-to-back loads therefore need at least 1 low cycle.
  - load_instr is sampled only at acceptance; changes afterwards are ignored.
  - load_req changes while busy are ignored.
- Reset mid-operation: all strobes drop immediately and asynchronously, and the partial shift is abandoned. The WIR contents are then undefined from the sequencer's view, and the WIR's own reset governs them. readback keeps its reset value of 0. Since armed=1 after reset, a held load_req starts a fresh transaction.
- WIR_LEN=1: SHIFT lasts one cycle; the counter compares against 0.

Decomposition:
- wir_pkg holds the state enum (IDLE/CAPTURE/SHIFT/UPDATE/DONE), the default WIR_LEN, and the named instruction opcodes (bypass, extest, intest) for requester use.
- No sub-module; the FSM, counter and shadow shifter stay in one module.
- The bench instantiates a WIR_LEN-cell WIR chain model driven by this block, with the chain's parallel output fed back as each cell's capture value.

Test Plan:
- Reset: assert WRSTN=0 with load_req=1 -> all outputs 0; release -> CAPTURE on the next edge after WRSTN rises.
- Normal load: WIR_LEN=3, chain holding 3'b010, load_instr=3'b101 ->
  - 1 capture cycle, 3 shift cycles with wir_si=1,0,1, then 1 update cycle.
  - Chain update outputs become 3'b101; readback=3'b010; readback_valid=1.
  - load_ack pulses exactly 5 cycles after acceptance.
- Held request: keep load_req=1 for 10 cycles past load_ack -> no second capture; drop for 1 cycle and raise again -> new transaction begins.
- Readback chaining: load 3'b110, then 3'b001 -> second readback=3'b110, and the chain holds 3'b001.
- Reset mid-shift: pull WRSTN low during the 2nd shift cycle -> wir_shift=0 within the same cycle, busy=0, readback=0; no load_ack pulse.
- Width edge: WIR_LEN=1, chain holding 0, load_instr=1 -> exactly 1 shift cycle, readback=0, chain=1, load_ack 3 cycles after acceptance.
